period_meter: RTL and testbench

Measures the period of an asynchronous square-wave input in `clk_50` cycles and reports a block-averaged period, a timeout flag and a lock indication against a programmable target. It sits on the receive side of the soft-PLL's `vco` output, on the returned signal from the external divider or loop, and is the measurement instrument for closed-loop testing and for the seven-segment display path.

---
 rtl/period_meter_pkg.sv | 15 +
 rtl/period_meter_if.sv | 23 ++
 rtl/period_meter_edge_sync.sv | 25 ++
 rtl/period_meter.sv | 135 +++++++++++++
 tb/tb_period_meter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/period_meter_pkg.sv
// Shared constants and state encoding for the period meter and its edge front end.
package period_meter_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_AVG_LOG2   = 2;
    // 1 ms at 50 MHz
    localparam int DEFAULT_TIMEOUT    = 50000;
    localparam int DEFAULT_LOCK_COUNT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/period_meter_if.sv
// Configuration and result bundle between the period meter and its consumer.
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] target;
    logic [7:0]       tol;
    logic [WIDTH-1:0] period_out;
    logic             period_valid;
    logic             timeout;
    logic             locked;

    modport master (
        output target, tol,
        input  period_out, period_valid, timeout, locked
    );

    modport slave (
        input  target, tol,
        output period_out, period_valid, timeout, locked
    );
endinterface

// File: rtl/period_meter_edge_sync.sv
// Two-flop synchronizer with rising-edge detect; shared by the vco and fb paths.
module edge_sync (
    input  logic clk_50,
    input  logic rst,
    input  logic in_u,
    output logic out_s,
    output logic rise
);
    logic sig_s0;
    logic sig_1a;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            sig_s0 <= 1'b0;
            out_s  <= 1'b0;
            sig_1a <= 1'b0;
        end else begin
            sig_s0 <= in_u;
            out_s  <= sig_s0;
            sig_1a <= out_s;
        end
    end

    assign rise = out_s & ~sig_1a;
endmodule

// File: rtl/period_meter.sv
// Counts clk_50 cycles between rising edges of sig_u, averages blocks of samples,
// flags loss of input and tracks lock against a programmable target.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int AVG_LOG2   = DEFAULT_AVG_LOG2,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic          clk_50,
    input  logic          rst,
    input  logic          sig_u,
    period_meter_if.slave bus
);
    localparam int ACC_W   = WIDTH + AVG_LOG2;
    localparam int NSAMP_W = AVG_LOG2 + 1;
    localparam int NSAMP   = 1 << AVG_LOG2;
    localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);
    localparam int DEV_W   = WIDTH + 1;

    state_t             state;
    state_t             state_next;
    logic               sync_level_unused;
    logic               rise;
    logic [WIDTH-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [NSAMP_W-1:0] nsamp;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [WIDTH-1:0]   avg;
    logic [DEV_W-1:0]   dev;
    logic               in_tol;
    logic               take_sample;
    logic               last_sample;
    logic               hit_timeout;

    edge_sync u_edge_sync (
        .clk_50 (clk_50),
        .rst    (rst),
        .in_u   (sig_u),
        .out_s  (sync_level_unused),
        .rise   (rise)
    );

    assign acc_sum = acc + ACC_W'(cnt);
    assign avg     = WIDTH'(acc_sum >> AVG_LOG2);
    assign dev     = (avg >= bus.target) ? ({1'b0, avg} - {1'b0, bus.target})
                                         : ({1'b0, bus.target} - {1'b0, avg});
    assign in_tol  = (dev <= DEV_W'(bus.tol));

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rise on the same cycle cnt reaches TIMEOUT is a valid sample, so cnt never wraps.
    always_comb begin
        state_next  = state;
        take_sample = 1'b0;
        last_sample = 1'b0;
        hit_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEAS;
                end
            end
            MEAS: begin
                if (rise) begin
                    take_sample = 1'b1;
                    last_sample = (nsamp == NSAMP_W'(NSAMP - 1));
                end else if (cnt == WIDTH'(TIMEOUT)) begin
                    hit_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            cnt              <= WIDTH'(1);
            acc              <= '0;
            nsamp            <= '0;
            lock_cnt         <= '0;
            bus.period_out   <= '0;
            bus.period_valid <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.locked       <= 1'b0;
        end else begin
            bus.period_valid <= 1'b0;
            if (state == IDLE) begin
                cnt   <= WIDTH'(1);
                acc   <= '0;
                nsamp <= '0;
                if (rise) begin
                    bus.timeout <= 1'b0;
                end
            end else if (take_sample) begin
                cnt <= WIDTH'(1);
                if (last_sample) begin
                    acc              <= '0;
                    nsamp            <= '0;
                    bus.period_out   <= avg;
                    bus.period_valid <= 1'b1;
                    if (in_tol) begin
                        if (int'(lock_cnt) < LOCK_COUNT) begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                        if (int'(lock_cnt) + 1 >= LOCK_COUNT) begin
                            bus.locked <= 1'b1;
                        end
                    end else begin
                        lock_cnt   <= '0;
                        bus.locked <= 1'b0;
                    end
                end else begin
                    acc   <= acc_sum;
                    nsamp <= nsamp + 1'b1;
                end
            end else if (hit_timeout) begin
                bus.timeout <= 1'b1;
                bus.locked  <= 1'b0;
                lock_cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// Drives two period_meter builds (4-sample/lock-4 and 1-sample/lock-1) from one waveform
// and scores their results and timeouts against an edge-timing reference model.
module tb_period_meter;
    localparam int TO = 600;

    typedef struct {
        int cycle;
        int period;
        int locked;
    } event_t;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;
    logic sig_u  = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    event_t rq0[$], rq1[$], tq0[$], tq1[$];
    bit     m_active[2];
    int     m_last[2], m_sum[2], m_n[2], m_lockn[2], m_locked[2], m_period[2];
    int     prev_to[2];
    int     cur_target = 0;
    int     cur_tol    = 0;

    period_meter_if #(.WIDTH(16)) bus0 ();
    period_meter_if #(.WIDTH(16)) bus1 ();

    period_meter #(.WIDTH(16), .AVG_LOG2(2), .TIMEOUT(TO), .LOCK_COUNT(4)) dut0 (
        .clk_50 (clk_50),
        .rst    (rst),
        .sig_u  (sig_u),
        .bus    (bus0)
    );

    period_meter #(.WIDTH(16), .AVG_LOG2(0), .TIMEOUT(TO), .LOCK_COUNT(1)) dut1 (
        .clk_50 (clk_50),
        .rst    (rst),
        .sig_u  (sig_u),
        .bus    (bus1)
    );

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    function automatic int avg_log2_of(int id);
        return (id == 0) ? 2 : 0;
    endfunction

    function automatic int lock_count_of(int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic void push_ev(int id, bit is_to, event_t e);
        if (is_to) begin
            if (id == 0) tq0.push_back(e); else tq1.push_back(e);
        end else begin
            if (id == 0) rq0.push_back(e); else rq1.push_back(e);
        end
    endfunction

    function automatic int ev_count(int id, bit is_to);
        if (is_to) return (id == 0) ? tq0.size() : tq1.size();
        return (id == 0) ? rq0.size() : rq1.size();
    endfunction

    function automatic event_t pop_ev(int id, bit is_to);
        if (is_to) return (id == 0) ? tq0.pop_front() : tq1.pop_front();
        return (id == 0) ? rq0.pop_front() : rq1.pop_front();
    endfunction

    // Any timeout due no later than cycle 'upto' is certain to happen before the next edge.
    function automatic void model_advance(int id, int upto);
        event_t e;
        if (m_active[id] && (m_last[id] + 2 + TO <= upto)) begin
            e.cycle  = m_last[id] + 2 + TO;
            e.period = m_period[id];
            e.locked = 0;
            push_ev(id, 1'b1, e);
            m_active[id] = 1'b0;
            m_lockn[id]  = 0;
            m_locked[id] = 0;
        end
    endfunction

    // cap is the clock edge that captures the rising edge; it is acted on two edges later.
    function automatic void model_edge(int id, int cap);
        event_t e;
        int     avg;
        int     dev;
        model_advance(id, cap + 1);
        if (!m_active[id]) begin
            m_active[id] = 1'b1;
            m_sum[id]    = 0;
            m_n[id]      = 0;
        end else begin
            m_sum[id] += cap - m_last[id];
            m_n[id]++;
            if (m_n[id] == (1 << avg_log2_of(id))) begin
                avg = m_sum[id] / (1 << avg_log2_of(id));
                dev = (avg > cur_target) ? avg - cur_target : cur_target - avg;
                if (dev <= cur_tol) begin
                    if (m_lockn[id] < lock_count_of(id)) m_lockn[id]++;
                    m_locked[id] = (m_lockn[id] >= lock_count_of(id)) ? 1 : 0;
                end else begin
                    m_lockn[id]  = 0;
                    m_locked[id] = 0;
                end
                m_period[id] = avg;
                e.cycle  = cap + 2;
                e.period = avg;
                e.locked = m_locked[id];
                push_ev(id, 1'b0, e);
                m_sum[id] = 0;
                m_n[id]   = 0;
            end
        end
        m_last[id] = cap;
    endfunction

    function automatic void model_reset();
        for (int id = 0; id < 2; id++) begin
            m_active[id] = 1'b0;
            m_lockn[id]  = 0;
            m_locked[id] = 0;
            m_period[id] = 0;
        end
        rq0.delete(); rq1.delete(); tq0.delete(); tq1.delete();
    endfunction

    task automatic check_output(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic monitor_dut(int id, logic valid, logic [15:0] pout, logic lk, logic to);
        event_t e;
        if (valid === 1'b1) begin
            if (ev_count(id, 1'b0) == 0) begin
                check_output($sformatf("dut%0d_unexpected_valid", id), 1, 0);
            end else begin
                e = pop_ev(id, 1'b0);
                check_output($sformatf("dut%0d_valid_cycle", id), cyc, e.cycle);
                check_output($sformatf("dut%0d_period_out", id), int'(pout), e.period);
                check_output($sformatf("dut%0d_locked", id), int'(lk), e.locked);
                check_output($sformatf("dut%0d_timeout_at_valid", id), int'(to), 0);
            end
        end
        if (to === 1'b1 && prev_to[id] == 0) begin
            if (ev_count(id, 1'b1) == 0) begin
                check_output($sformatf("dut%0d_unexpected_timeout", id), 1, 0);
            end else begin
                e = pop_ev(id, 1'b1);
                check_output($sformatf("dut%0d_timeout_cycle", id), cyc, e.cycle);
                check_output($sformatf("dut%0d_retained_period", id), int'(pout), e.period);
                check_output($sformatf("dut%0d_locked_at_timeout", id), int'(lk), 0);
            end
        end
        prev_to[id] = (to === 1'b1) ? 1 : 0;
    endtask

    always @(negedge clk_50) begin
        monitor_dut(0, bus0.period_valid, bus0.period_out, bus0.locked, bus0.timeout);
        monitor_dut(1, bus1.period_valid, bus1.period_out, bus1.locked, bus1.timeout);
    end

    task automatic set_target(int t, int tl);
        cur_target  = t;
        cur_tol     = tl;
        bus0.target = 16'(t);
        bus1.target = 16'(t);
        bus0.tol    = 8'(tl);
        bus1.tol    = 8'(tl);
    endtask

    task automatic check_reset_state();
        check_output("dut0_rst_period_out", int'(bus0.period_out), 0);
        check_output("dut0_rst_valid", int'(bus0.period_valid), 0);
        check_output("dut0_rst_timeout", int'(bus0.timeout), 0);
        check_output("dut0_rst_locked", int'(bus0.locked), 0);
        check_output("dut1_rst_period_out", int'(bus1.period_out), 0);
        check_output("dut1_rst_valid", int'(bus1.period_valid), 0);
        check_output("dut1_rst_timeout", int'(bus1.timeout), 0);
        check_output("dut1_rst_locked", int'(bus1.locked), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk_50);
        rst = 1'b0;
        check_reset_state();
    endtask

    // One period of sig_u: high for h cycles then low for l cycles, starting at a negedge.
    task automatic apply_stimulus(int h, int l);
        sig_u = 1'b1;
        for (int id = 0; id < 2; id++) begin
            model_edge(id, cyc + 1);
            model_advance(id, cyc + h + l + 2);
        end
        repeat (h) @(negedge clk_50);
        sig_u = 1'b0;
        repeat (l) @(negedge clk_50);
    endtask

    task automatic apply_stimulus_with_reset(int h, int l);
        sig_u = 1'b1;
        for (int id = 0; id < 2; id++) begin
            model_edge(id, cyc + 1);
            model_advance(id, cyc + h + l / 2);
        end
        repeat (h) @(negedge clk_50);
        sig_u = 1'b0;
        repeat (l / 2) @(negedge clk_50);
        apply_reset();
        repeat (l - l / 2 - 1) @(negedge clk_50);
    endtask

    task automatic hold_low(int n);
        sig_u = 1'b0;
        for (int id = 0; id < 2; id++) model_advance(id, cyc + n + 2);
        repeat (n) @(negedge clk_50);
    endtask

    initial begin
        int p;
        int h;
        set_target(0, 0);
        model_reset();
        repeat (3) @(negedge clk_50);
        apply_reset();

        $display("[TB] steady period 100");
        set_target(100, 2);
        repeat (24) apply_stimulus(50, 50);

        $display("[TB] jittered 99/101 then 103");
        for (int i = 0; i < 16; i++) apply_stimulus(50, (i % 2 == 0) ? 49 : 51);
        repeat (10) apply_stimulus(51, 52);

        $display("[TB] randomized periods");
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) set_target($urandom_range(20, 200), $urandom_range(0, 60));
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 5, TO + 5) : $urandom_range(4, 200);
            h = $urandom_range(2, p - 2);
            apply_stimulus(h, p - h);
        end

        $display("[TB] input stops after lock");
        set_target(100, 2);
        repeat (10) apply_stimulus(50, 50);
        hold_low(TO + 50);
        repeat (6) apply_stimulus(50, 50);

        $display("[TB] boundary periods");
        set_target(TO, 0);
        repeat (6) apply_stimulus(TO / 2, TO / 2);
        repeat (4) apply_stimulus(TO / 2, TO / 2 + 1);

        $display("[TB] reset during third sample");
        set_target(80, 1);
        repeat (2) apply_stimulus(40, 60);
        apply_stimulus_with_reset(40, 60);
        repeat (6) apply_stimulus(40, 40);

        $display("[TB] period 37");
        set_target(37, 0);
        repeat (10) apply_stimulus(18, 19);

        hold_low(10);
        for (int id = 0; id < 2; id++) begin
            check_output($sformatf("dut%0d_missing_results", id), ev_count(id, 1'b0), 0);
            check_output($sformatf("dut%0d_missing_timeouts", id), ev_count(id, 1'b1), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
